mem_access_initiator: RTL and testbench
=======================================

Name: mem_access_initiator

Overview:
- Initiator side of the word-addressed memory interface.
- Accepts single load/store requests from the datapath (MAR/MDR side) and sequences the memory's read, write, address and data_in strobes.
- Captures the memory's data_out into a response register and signals completion with a one-cycle pulse.
- Sits between the control unit and the RAM block; one outstanding transaction at a time.

Parameters:
- DATA_WIDTH, 32, word width of request data, memory data and response data.
- ADDRESS_WIDTH, 9, word address width.
- MEM_SIZE, 512, number of implemented words; used only by the optional bounds check.
- READ_LATENCY, 1, cycles mem_read is held before mem_data_out is sampled. Legal range 1..15.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- clr_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  initiator can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load; sampled on accept.
- req_addr  input  ADDRESS_WIDTH  word address; sampled on accept.
- req_wdata  input  DATA_WIDTH  store data; sampled on accept.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_WIDTH  last load result.
- busy  output  1  transaction in flight; equals NOT req_ready.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_address  output  ADDRESS_WIDTH  memory address.
- mem_data_in  output  DATA_WIDTH  write data to memory.
- mem_data_out  input  DATA_WIDTH  read data from memory.

Behaviour:
- Reset (clr_n=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1 (once released); busy=0; rsp_valid=0.
  - mem_read=0, mem_write=0 (strobes drop immediately, including mid-transaction).
  - mem_address=0, mem_data_in=0, rsp_rdata=0, latency counter=0.
  - An interrupted transaction is discarded: no rsp_valid is ever produced for it.
- IDLE:
  - req_ready=1.
  - Accept on rising edge with req_valid=1: latch req_write, req_addr to mem_address, req_wdata to mem_data_in; go to ISSUE.
  - req_* inputs are don't-care after the accept edge.
- ISSUE, store:
  - mem_write=1 for exactly one cycle; mem_address and mem_data_in are stable for the whole cycle.
  - Next state is DONE.
- ISSUE, load:
  - mem_read=1 for READ_LATENCY cycles; counter loads READ_LATENCY-1 on entry and decrements each cycle.
  - On the edge where counter=0: capture mem_data_out into rsp_rdata, go to DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle; strobes 0; next state IDLE.
  - A store leaves rsp_rdata unchanged.
- Outside IDLE: req_ready=0 and requests are ignored (not queued).
- mem_read and mem_write are never both 1. Both are 0 in IDLE and DONE.
- mem_address and mem_data_in hold their last latched value between transactions.
- Latency, accept edge to rsp_valid high:
  - store: 2 cycles.
  - load: READ_LATENCY+1 cycles.
  - back-to-back throughput: one transaction per latency+1 cycles (DONE then IDLE accept).
- Address width: mem_address is passed through at ADDRESS_WIDTH bits with no arithmetic; addresses at or above MEM_SIZE wrap per the memory.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined:
  - Adds output rsp_error (1 bit, reset 0).
  - On accept with req_addr >= MEM_SIZE, skip ISSUE and go directly to DONE; no strobe is asserted.
  - rsp_valid=1 with rsp_error=1 in that DONE cycle; rsp_rdata unchanged.
  - rsp_error=0 on all in-range completions.
- Not defined: no rsp_error port, no comparison; every request issues to memory.

Test Plan:
- Reset then store: req addr=0x005, wdata=0xDEADBEEF -> mem_write high exactly 1 cycle with addr 0x005 and data 0xDEADBEEF; rsp_valid 2 cycles after accept; rsp_rdata stays 0.
- Load after store, READ_LATENCY=1, behavioural memory returns 0xDEADBEEF at 0x005 -> mem_read high 1 cycle; rsp_valid 2 cycles after accept; rsp_rdata=0xDEADBEEF.
- READ_LATENCY=3, load addr 0x1FF, memory returns 0x12345678 -> mem_read high 3 consecutive cycles; rsp_rdata=0x12345678 with rsp_valid 4 cycles after accept.
- req_valid held high continuously during a load -> exactly one accept per IDLE visit; req_ready=0 for the whole transaction; no dropped or duplicated strobes.
- clr_n pulsed low mid-ISSUE of a load -> mem_read falls in the same cycle without a clock edge; rsp_valid never asserts; rsp_rdata=0; next request works normally.
- MEM_BOUNDS_CHECK_EN with MEM_SIZE=256, load addr 0x100 -> no strobe; rsp_valid and rsp_error high 1 cycle after accept. Then addr 0x0FF -> normal load with rsp_error=0.

Source files
------------

// File: rtl/mem_access_initiator.sv
// Single-outstanding load/store initiator for the word-addressed RAM.
// Optional MEM_BOUNDS_CHECK_EN adds rsp_error and rejects addresses >= MEM_SIZE without touching memory.
module mem_access_initiator #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 9,
    parameter int MEM_SIZE      = 512,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     Clock,
    input  logic                     clr_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     busy,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic [DATA_WIDTH-1:0]    mem_data_out
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic                     rsp_error
`endif
);

    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
        $error("mem_access_initiator: READ_LATENCY must be 1..15");
    end
    if (MEM_SIZE < 1 || MEM_SIZE > (2 ** ADDRESS_WIDTH)) begin : g_bad_size
        $error("mem_access_initiator: MEM_SIZE must be 1..2**ADDRESS_WIDTH");
    end

    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t     state;
    logic       is_write;
    logic [3:0] lat_cnt;

`ifdef MEM_BOUNDS_CHECK_EN
    logic out_of_range;
    assign out_of_range = 32'(req_addr) >= 32'(MEM_SIZE);
`endif

    assign busy = !req_ready;

    always_ff @(posedge Clock or negedge clr_n) begin
        if (!clr_n) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            lat_cnt     <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
            rsp_error   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            rsp_error <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_write    <= req_write;
                        mem_address <= req_addr;
                        mem_data_in <= req_wdata;
                        req_ready   <= 1'b0;
                        lat_cnt     <= LAT_LOAD;
`ifdef MEM_BOUNDS_CHECK_EN
                        // Rejected requests complete immediately with no strobe.
                        if (out_of_range) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            mem_write <= req_write;
                            mem_read  <= !req_write;
                        end
`else
                        state     <= ISSUE;
                        mem_write <= req_write;
                        mem_read  <= !req_write;
`endif
                    end
                end
                ISSUE: begin
                    if (is_write) begin
                        mem_write <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else if (lat_cnt == '0) begin
                        mem_read  <= 1'b0;
                        rsp_rdata <= mem_data_out;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench: two initiators (READ_LATENCY 1 and 3) each driving a behavioural RAM.
// The MEM_BOUNDS_CHECK_EN section runs only when that macro is defined for the build.
module tb_mem_access_initiator;

    logic        clk;
    logic        clr_n;

    logic        req1_valid, req1_write, r1_ready, r1_valid, busy1, mrd1, mwr1;
    logic [8:0]  req1_addr, maddr1;
    logic [31:0] req1_wdata, r1_rdata, mdin1, mdout1;

    logic        req3_valid, req3_write, r3_ready, r3_valid, busy3, mrd3, mwr3;
    logic [8:0]  req3_addr, maddr3;
    logic [31:0] req3_wdata, r3_rdata, mdin3, mdout3;

`ifdef MEM_BOUNDS_CHECK_EN
    logic        err1, err3;
`endif

    int checks;
    int failures;

    logic [31:0] mem1 [0:511];
    logic [31:0] mem3 [0:511];

    assign mdout1 = mem1[maddr1];
    assign mdout3 = mem3[maddr3];

    always @(posedge clk) begin
        if (mwr1) mem1[maddr1] <= mdin1;
        if (mwr3) mem3[maddr3] <= mdin3;
    end

    mem_access_initiator #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(9), .MEM_SIZE(256), .READ_LATENCY(1)
    ) u_dut1 (
        .Clock(clk), .clr_n(clr_n),
        .req_valid(req1_valid), .req_ready(r1_ready), .req_write(req1_write),
        .req_addr(req1_addr), .req_wdata(req1_wdata),
        .rsp_valid(r1_valid), .rsp_rdata(r1_rdata), .busy(busy1),
        .mem_read(mrd1), .mem_write(mwr1), .mem_address(maddr1),
        .mem_data_in(mdin1), .mem_data_out(mdout1)
`ifdef MEM_BOUNDS_CHECK_EN
        , .rsp_error(err1)
`endif
    );

    mem_access_initiator #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(9), .MEM_SIZE(512), .READ_LATENCY(3)
    ) u_dut3 (
        .Clock(clk), .clr_n(clr_n),
        .req_valid(req3_valid), .req_ready(r3_ready), .req_write(req3_write),
        .req_addr(req3_addr), .req_wdata(req3_wdata),
        .rsp_valid(r3_valid), .rsp_rdata(r3_rdata), .busy(busy3),
        .mem_read(mrd3), .mem_write(mwr3), .mem_address(maddr3),
        .mem_data_in(mdin3), .mem_data_out(mdout3)
`ifdef MEM_BOUNDS_CHECK_EN
        , .rsp_error(err3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clr_n = 1'b1;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        req3_valid = 0; req3_write = 0; req3_addr = '0; req3_wdata = '0;
        #2 clr_n = 1'b0;
        tick();
        check("rst_ready", r1_ready, 1);
        check("rst_busy", busy1, 0);
        check("rst_rsp_valid", r1_valid, 0);
        check("rst_mem_read", mrd1, 0);
        check("rst_mem_write", mwr1, 0);
        check("rst_mem_address", maddr1, 0);
        check("rst_mem_data_in", mdin1, 0);
        check("rst_rsp_rdata", r1_rdata, 0);
        check("rst3_mem_read", mrd3, 0);
        #2 clr_n = 1'b1;
        tick();
        check("post_rst_ready", r1_ready, 1);

        // store 0xDEADBEEF to 0x005
        req1_valid = 1; req1_write = 1; req1_addr = 9'h005; req1_wdata = 32'hDEADBEEF;
        tick();
        check("st_mem_write", mwr1, 1);
        check("st_mem_read", mrd1, 0);
        check("st_addr", maddr1, 9'h005);
        check("st_data", mdin1, 32'hDEADBEEF);
        check("st_ready_low", r1_ready, 0);
        check("st_busy", busy1, 1);
        check("st_rsp_early", r1_valid, 0);
        req1_valid = 0; req1_addr = 9'h1AA; req1_wdata = 32'h0BAD0BAD;
        tick();
        check("st_write_one_cycle", mwr1, 0);
        check("st_rsp_valid", r1_valid, 1);
        check("st_rdata_unchanged", r1_rdata, 0);
        check("st_addr_hold", maddr1, 9'h005);
        check("st_data_hold", mdin1, 32'hDEADBEEF);
        tick();
        check("st_rsp_pulse", r1_valid, 0);
        check("st_ready_back", r1_ready, 1);
        check("st_busy_back", busy1, 0);

        // load back from 0x005, READ_LATENCY=1
        req1_valid = 1; req1_write = 0; req1_addr = 9'h005;
        tick();
        check("ld_mem_read", mrd1, 1);
        check("ld_mem_write", mwr1, 0);
        check("ld_rsp_early", r1_valid, 0);
        req1_valid = 0;
        tick();
        check("ld_read_one_cycle", mrd1, 0);
        check("ld_rsp_valid", r1_valid, 1);
        check("ld_rdata", r1_rdata, 32'hDEADBEEF);
        tick();
        check("ld_rsp_pulse", r1_valid, 0);
        check("ld_ready_back", r1_ready, 1);

        // req_valid held high: one accept per IDLE visit
        req1_valid = 1; req1_write = 0; req1_addr = 9'h005;
        tick();
        check("hv_read_e0", mrd1, 1);
        check("hv_ready_e0", r1_ready, 0);
        tick();
        check("hv_read_e1", mrd1, 0);
        check("hv_valid_e1", r1_valid, 1);
        check("hv_ready_e1", r1_ready, 0);
        tick();
        check("hv_read_e2", mrd1, 0);
        check("hv_valid_e2", r1_valid, 0);
        check("hv_ready_e2", r1_ready, 1);
        tick();
        check("hv_read_e3", mrd1, 1);
        check("hv_ready_e3", r1_ready, 0);
        check("hv_write_e3", mwr1, 0);
        req1_valid = 0;
        tick();
        check("hv_valid_e4", r1_valid, 1);
        check("hv_read_e4", mrd1, 0);
        tick();
        check("hv_ready_e5", r1_ready, 1);
        check("hv_read_e5", mrd1, 0);

        // READ_LATENCY=3: seed 0x1FF through the initiator, then load it
        req3_valid = 1; req3_write = 1; req3_addr = 9'h1FF; req3_wdata = 32'h12345678;
        tick();
        check("s3_write", mwr3, 1);
        check("s3_addr", maddr3, 9'h1FF);
        req3_valid = 0;
        tick();
        check("s3_rsp_valid", r3_valid, 1);
        tick();
        req3_valid = 1; req3_write = 0; req3_addr = 9'h1FF;
        tick();
        check("l3_read_e0", mrd3, 1);
        check("l3_valid_e0", r3_valid, 0);
        req3_valid = 0;
        tick();
        check("l3_read_e1", mrd3, 1);
        check("l3_valid_e1", r3_valid, 0);
        tick();
        check("l3_read_e2", mrd3, 1);
        check("l3_valid_e2", r3_valid, 0);
        tick();
        check("l3_read_e3", mrd3, 0);
        check("l3_valid_e3", r3_valid, 1);
        check("l3_rdata", r3_rdata, 32'h12345678);
        tick();
        check("l3_valid_pulse", r3_valid, 0);
        check("l3_ready_back", r3_ready, 1);

        // reset asserted mid-ISSUE of a load, away from any clock edge
        req3_valid = 1; req3_write = 0; req3_addr = 9'h1FF;
        tick();
        req3_valid = 0;
        tick();
        check("rr_read_before", mrd3, 1);
        #2 clr_n = 1'b0;
        #1;
        check("rr_read_async", mrd3, 0);
        check("rr_rdata_cleared", r3_rdata, 0);
        check("rr_ready", r3_ready, 1);
        check("rr_busy", busy3, 0);
        check("rr_dut1_rdata_cleared", r1_rdata, 0);
        #1 clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_no_rsp", r3_valid, 0);
            check("rr_no_read", mrd3, 0);
        end

        // normal traffic after the interrupted load
        req3_valid = 1; req3_write = 1; req3_addr = 9'h00A; req3_wdata = 32'hA5A5A5A5;
        tick();
        check("ar_write", mwr3, 1);
        check("ar_data", mdin3, 32'hA5A5A5A5);
        req3_valid = 0;
        tick();
        check("ar_st_valid", r3_valid, 1);
        check("ar_st_rdata", r3_rdata, 0);
        tick();
        req3_valid = 1; req3_write = 0; req3_addr = 9'h00A;
        tick();
        req3_valid = 0;
        tick();
        tick();
        check("ar_ld_not_yet", r3_valid, 0);
        tick();
        check("ar_ld_valid", r3_valid, 1);
        check("ar_ld_rdata", r3_rdata, 32'hA5A5A5A5);
        tick();

`ifdef MEM_BOUNDS_CHECK_EN
        // MEM_SIZE=256 on u_dut1: seed 0x0FF, then probe 0x100 and 0x0FF
        req1_valid = 1; req1_write = 1; req1_addr = 9'h0FF; req1_wdata = 32'hCAFEF00D;
        tick();
        check("bc_seed_write", mwr1, 1);
        check("bc_seed_err", err1, 0);
        req1_valid = 0;
        tick();
        check("bc_seed_err_done", err1, 0);
        tick();
        req1_valid = 1; req1_write = 0; req1_addr = 9'h100;
        tick();
        check("bc_oob_read", mrd1, 0);
        check("bc_oob_write", mwr1, 0);
        check("bc_oob_valid", r1_valid, 1);
        check("bc_oob_err", err1, 1);
        check("bc_oob_rdata", r1_rdata, 0);
        req1_valid = 0;
        tick();
        check("bc_oob_valid_pulse", r1_valid, 0);
        check("bc_oob_err_pulse", err1, 0);
        check("bc_oob_ready", r1_ready, 1);
        req1_valid = 1; req1_write = 0; req1_addr = 9'h0FF;
        tick();
        check("bc_in_read", mrd1, 1);
        req1_valid = 0;
        tick();
        check("bc_in_valid", r1_valid, 1);
        check("bc_in_err", err1, 0);
        check("bc_in_rdata", r1_rdata, 32'hCAFEF00D);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
